// File: rtl/irq_exc_ctrl_pkg.sv
// Shared CPU package: interrupt/exception controller states and vectors.
// Imported by irq_exc_ctrl.
package irq_exc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT     = 3'd1,
    ST_TAKE_IRQ = 3'd2,
    ST_TAKE_EXC = 3'd3,
    ST_KERNEL   = 3'd4
  } irq_state_t;

  localparam logic [31:0] IRQ_VEC = 32'h8000_0004;
  localparam logic [31:0] EXC_VEC = 32'h8000_0008;

  function automatic logic is_take(input irq_state_t s);
    return (s == ST_TAKE_IRQ) || (s == ST_TAKE_EXC);
  endfunction

endpackage

// File: rtl/irq_exc_ctrl.sv
// Interrupt / exception controller: takes one event at a time,
// redirects the PC, saves EPC and tracks kernel mode.
module irq_exc_ctrl
  import irq_exc_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        irq_req,
  input  logic        irq_en,
  input  logic        exc_req,
  input  logic        eret,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] pc_id,
  output logic        intterupt,
  output logic        exception,
  output logic [31:0] redirect_pc,
  output logic [31:0] epc,
  output logic        kernel_mode,
  output logic        irq_ack,
  output logic        nested_err,
  output logic [7:0]  taken_cnt
);

  irq_state_t  r_state;
  irq_state_t  w_next;
  logic [31:0] r_epc;
  logic [7:0]  r_cnt;
  logic        r_nerr;
  logic        w_irq;
  logic        w_go;

  assign w_irq = irq_req & irq_en;
  assign w_go  = ~stall & ~flush;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE, ST_WAIT: begin
        if (exc_req)
          w_next = ST_TAKE_EXC;
        else if (w_irq)
          w_next = w_go ? ST_TAKE_IRQ : ST_WAIT;
        else
          w_next = ST_IDLE;
      end
      ST_TAKE_IRQ,
      ST_TAKE_EXC: w_next = ST_KERNEL;
      ST_KERNEL: begin
        if (eret)
          w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_state <= ST_IDLE;
    else
      r_state <= w_next;
  end

  // EPC and count update on the edge entering a TAKE state so
  // they are already valid alongside the redirect pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_epc <= 32'd0;
      r_cnt <= 8'd0;
    end else if (is_take(w_next) && !is_take(r_state)) begin
      r_epc <= (w_next == ST_TAKE_EXC) ? pc_id + 32'd4 : pc_id;
      r_cnt <= r_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_nerr <= 1'b0;
    else if (r_state == ST_KERNEL && exc_req)
      r_nerr <= 1'b1;
  end

  assign intterupt   = (r_state == ST_TAKE_IRQ);
  assign exception   = (r_state == ST_TAKE_EXC);
  assign irq_ack     = intterupt;
  assign kernel_mode = is_take(r_state) || (r_state == ST_KERNEL);
  assign redirect_pc = intterupt ? IRQ_VEC :
                       exception ? EXC_VEC : 32'd0;
  assign epc         = r_epc;
  assign taken_cnt   = r_cnt;
  assign nested_err  = r_nerr;

endmodule

// File: tb/tb_irq_exc_ctrl.sv
// Directed bench for irq_exc_ctrl.
// Expected values are hand-derived constants.
module tb_irq_exc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        irq_req, irq_en, exc_req, eret;
  logic        stall, flush;
  logic [31:0] pc_id;
  logic        intterupt, exception, kernel_mode;
  logic        irq_ack, nested_err;
  logic [31:0] redirect_pc, epc;
  logic [7:0]  taken_cnt;

  int total = 0;
  int bad   = 0;

  irq_exc_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .irq_req     (irq_req),
    .irq_en      (irq_en),
    .exc_req     (exc_req),
    .eret        (eret),
    .stall       (stall),
    .flush       (flush),
    .pc_id       (pc_id),
    .intterupt   (intterupt),
    .exception   (exception),
    .redirect_pc (redirect_pc),
    .epc         (epc),
    .kernel_mode (kernel_mode),
    .irq_ack     (irq_ack),
    .nested_err  (nested_err),
    .taken_cnt   (taken_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".irq"},  {31'd0, intterupt}, 32'd0);
    chk({tag, ".exc"},  {31'd0, exception}, 32'd0);
    chk({tag, ".ack"},  {31'd0, irq_ack}, 32'd0);
    chk({tag, ".kern"}, {31'd0, kernel_mode}, 32'd0);
    chk({tag, ".nerr"}, {31'd0, nested_err}, 32'd0);
    chk({tag, ".rpc"},  redirect_pc, 32'd0);
    chk({tag, ".epc"},  epc, 32'd0);
    chk({tag, ".cnt"},  {24'd0, taken_cnt}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    irq_req = 0; irq_en = 0; exc_req = 0; eret = 0;
    stall = 0; flush = 0; pc_id = 32'd0;
    #1 reset = 1'b0;
    #1 chk_zero("rst");
    step();
    step();
    reset = 1'b1;
    step();
    chk_zero("idle");

    // plain interrupt
    irq_req = 1; irq_en = 1; pc_id = 32'h40;
    step();
    chk("s1.irq", {31'd0, intterupt}, 32'd1);
    chk("s1.ack", {31'd0, irq_ack}, 32'd1);
    chk("s1.exc", {31'd0, exception}, 32'd0);
    chk("s1.rpc", redirect_pc, 32'h8000_0004);
    chk("s1.epc", epc, 32'h40);
    chk("s1.cnt", {24'd0, taken_cnt}, 32'd1);
    chk("s1.kern", {31'd0, kernel_mode}, 32'd1);
    irq_req = 0; pc_id = 32'h44;
    step();
    chk("s1k.irq", {31'd0, intterupt}, 32'd0);
    chk("s1k.rpc", redirect_pc, 32'd0);
    chk("s1k.kern", {31'd0, kernel_mode}, 32'd1);
    chk("s1k.epc", epc, 32'h40);
    eret = 1;
    step();
    eret = 0;
    chk("s1r.kern", {31'd0, kernel_mode}, 32'd0);

    // stalled interrupt
    irq_req = 1; stall = 1; pc_id = 32'h100;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("s2.wait.irq", {31'd0, intterupt}, 32'd0);
      chk("s2.wait.kern", {31'd0, kernel_mode}, 32'd0);
    end
    stall = 0; pc_id = 32'h104;
    step();
    chk("s2.irq", {31'd0, intterupt}, 32'd1);
    chk("s2.epc", epc, 32'h104);
    chk("s2.cnt", {24'd0, taken_cnt}, 32'd2);
    irq_req = 0;
    step();
    eret = 1;
    step();
    eret = 0;

    // WAIT abandoned when the request drops
    irq_req = 1; flush = 1;
    step();
    chk("s2d.wait", {31'd0, intterupt}, 32'd0);
    irq_req = 0; flush = 0;
    step();
    chk("s2d.idle", {31'd0, intterupt}, 32'd0);
    step();
    chk("s2d.none", {31'd0, intterupt}, 32'd0);
    chk("s2d.cnt", {24'd0, taken_cnt}, 32'd2);

    // simultaneous exception and interrupt, EPC wraps
    exc_req = 1; irq_req = 1; pc_id = 32'hFFFF_FFFC;
    step();
    chk("s3.exc", {31'd0, exception}, 32'd1);
    chk("s3.irq", {31'd0, intterupt}, 32'd0);
    chk("s3.ack", {31'd0, irq_ack}, 32'd0);
    chk("s3.epc", epc, 32'h0);
    chk("s3.rpc", redirect_pc, 32'h8000_0008);
    chk("s3.cnt", {24'd0, taken_cnt}, 32'd3);
    exc_req = 0; irq_req = 0;
    step();

    // nested events in kernel, then return
    irq_req = 1; exc_req = 1;
    step();
    chk("s4.irq", {31'd0, intterupt}, 32'd0);
    chk("s4.exc", {31'd0, exception}, 32'd0);
    chk("s4.nerr", {31'd0, nested_err}, 32'd1);
    chk("s4.kern", {31'd0, kernel_mode}, 32'd1);
    chk("s4.cnt", {24'd0, taken_cnt}, 32'd3);
    exc_req = 0; eret = 1; pc_id = 32'h200;
    step();
    eret = 0;
    chk("s4r.kern", {31'd0, kernel_mode}, 32'd0);
    chk("s4r.irq", {31'd0, intterupt}, 32'd0);
    step();
    chk("s4t.irq", {31'd0, intterupt}, 32'd1);
    chk("s4t.epc", epc, 32'h200);
    chk("s4t.cnt", {24'd0, taken_cnt}, 32'd4);
    irq_req = 0;
    step();
    eret = 1;
    step();

    // eret outside kernel is ignored
    step();
    eret = 0;
    chk("s5.kern", {31'd0, kernel_mode}, 32'd0);
    chk("s5.epc", epc, 32'h200);
    chk("s5.nerr", {31'd0, nested_err}, 32'd1);

    // counter wrap: 252 more exceptions
    pc_id = 32'h300;
    for (int i = 0; i < 252; i++) begin
      exc_req = 1;
      step();
      if (i == 250)
        chk("s6.cnt255", {24'd0, taken_cnt}, 32'd255);
      exc_req = 0;
      if (i < 251) begin
        eret = 1;
        step();
        step();
        eret = 0;
      end
    end
    chk("s6.exc", {31'd0, exception}, 32'd1);
    chk("s6.cnt0", {24'd0, taken_cnt}, 32'd0);
    chk("s6.epc", epc, 32'h304);
    step();
    chk("s6.kern", {31'd0, kernel_mode}, 32'd1);

    // asynchronous reset mid-kernel
    #3 reset = 1'b0;
    #1 chk_zero("s7");
    step();
    reset = 1'b1;
    step();

    // reset aborts a TAKE pulse
    exc_req = 1; pc_id = 32'h500;
    step();
    chk("s8.exc", {31'd0, exception}, 32'd1);
    #2 reset = 1'b0;
    #1 chk_zero("s8");
    exc_req = 0;
    step();
    reset = 1'b1;
    step();
    chk("s8.after", {31'd0, exception}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  always @(negedge clk)
    if (intterupt && exception) begin
      total++;
      bad++;
      $display("FAIL both_pulses: got 1 want 0");
    end

  initial begin
    #200000;
    $display("FAIL timeout: got hang want finish");
    $fatal(1);
  end

endmodule

// File: doc/irq_exc_ctrl.md
IRQ_EXC_CTRL -- requirements
Module: irq_exc_ctrl

Interface
REQ-001 The module SHALL have port `clk`: input, 1 bit, the single clock; all state updates on the rising edge.
REQ-002 The module SHALL have port `reset`: input, 1 bit, asynchronous, active-low; the clock is the only clock.
REQ-003 The module SHALL have port `irq_req`: input, 1 bit, level-sensitive external/timer interrupt request.
REQ-004 The module SHALL have port `irq_en`: input, 1 bit, global interrupt enable.
REQ-005 The module SHALL have port `exc_req`: input, 1 bit, undefined-instruction flag from ID, valid in the current cycle.
REQ-006 The module SHALL have port `eret`: input, 1 bit, return-from-handler decoded in ID.
REQ-007 The module SHALL have port `stall`: input, 1 bit, load-use stall from the hazard unit.
REQ-008 The module SHALL have port `flush`: input, 1 bit, branch/jump flush from the hazard unit.
REQ-009 The module SHALL have port `pc_id`: input, 32 bits, PC of the instruction in ID.
REQ-010 The module SHALL have port `intterupt`: output, 1 bit, one-cycle pulse that squashes IF/ID and redirects the PC.
REQ-011 The module SHALL have port `exception`: output, 1 bit, one-cycle pulse, same role as `intterupt`.
REQ-012 The module SHALL have port `redirect_pc`: output, 32 bits, handler vector; valid while either pulse is high.
REQ-013 The module SHALL have port `epc`: output, 32 bits, saved return address.
REQ-014 The module SHALL have port `kernel_mode`: output, 1 bit, high while a handler is running.
REQ-015 The module SHALL have port `irq_ack`: output, 1 bit, pulses in the same cycle as `intterupt`.
REQ-016 The module SHALL have port `nested_err`: output, 1 bit, sticky flag; set when `exc_req` arrives in kernel mode.
REQ-017 The module SHALL have port `taken_cnt`: output, 8 bits, count of events taken; wraps from 255 to 0.

Function
REQ-018 The module SHALL implement a state machine with states IDLE, WAIT, TAKE_IRQ, TAKE_EXC and KERNEL.
REQ-019 In IDLE, `exc_req`=1 SHALL move to TAKE_EXC next cycle, regardless of `stall`, `flush` or `irq_req`; exception has priority.
REQ-020 In IDLE, `irq_req`&`irq_en`=1 with `exc_req`=0 SHALL go to TAKE_IRQ next cycle if `stall`=`flush`=0, else to WAIT.
REQ-021 In WAIT, the controller SHALL go to TAKE_IRQ in the first cycle with `stall`=`flush`=0.
REQ-022 In WAIT, if `irq_req`&`irq_en` drops, the controller SHALL return to IDLE with no pulse.
REQ-023 In WAIT, `exc_req` SHALL take priority and move the controller to TAKE_EXC.
REQ-024 TAKE_IRQ SHALL last exactly one cycle and SHALL do all of the following:
- assert `intterupt` and `irq_ack`;
- set `redirect_pc`=0x8000_0004;
- latch `epc`=`pc_id` (interrupted instruction re-executes);
- enter KERNEL.
REQ-025 TAKE_EXC SHALL last exactly one cycle and SHALL do all of the following:
- assert `exception`;
- set `redirect_pc`=0x8000_0008;
- latch `epc`=`pc_id`+4 (mod 2^32, faulting instruction skipped);
- enter KERNEL.
REQ-026 Each TAKE state SHALL increment `taken_cnt` by 1.
REQ-027 Latency from a qualifying IDLE sample to the pulse SHALL be exactly 1 cycle.
REQ-028 `intterupt` and `exception` SHALL never be high in the same cycle.
REQ-029 `kernel_mode` SHALL be 1 in TAKE_IRQ, TAKE_EXC and KERNEL, and 0 in all other states.
REQ-030 In KERNEL, `irq_req` SHALL be ignored, and `exc_req` SHALL set `nested_err` with no state change.
REQ-031 In KERNEL, `eret`=1 SHALL return to IDLE next cycle; a pending `irq_req` is then evaluated from IDLE, giving at least 1 cycle of user execution.
REQ-032 `eret` outside KERNEL SHALL be ignored.
REQ-033 `epc` SHALL hold its value except in TAKE states.
REQ-034 `redirect_pc` SHALL be 0 when no pulse is active.

Reset
REQ-035 While `reset`=0, the controller SHALL immediately force state IDLE and drive the following outputs:
- `epc`=0, `taken_cnt`=0;
- `nested_err`=0, `kernel_mode`=0;
- `intterupt`=0, `exception`=0, `irq_ack`=0;
- `redirect_pc`=0.
REQ-036 Reset asserted during TAKE or KERNEL SHALL abort the event with no pulse completed.
REQ-037 `nested_err` SHALL clear only on reset.

Structure
REQ-038 The state enum and the vector constants IRQ_VEC=0x8000_0004 and EXC_VEC=0x8000_0008 SHALL live in the shared CPU package.
REQ-039 No sub-module SHALL be used: one FSM plus `epc`/counter registers.

Verification
REQ-040 Scenario (plain interrupt): `irq_req`=`irq_en`=1, `stall`=`flush`=0, `pc_id`=0x0000_0040 -> next cycle `intterupt`=1 and `irq_ack`=1 for one cycle, `redirect_pc`=0x8000_0004, `epc`=0x40, `taken_cnt`=1.
REQ-041 Scenario (stalled interrupt): `irq_req`=1 with `stall`=1 for 3 cycles -> no pulse during the stall; pulse in the cycle after `stall` falls, `epc`=`pc_id` sampled then.
REQ-042 Scenario (simultaneous events): `exc_req`=1 and `irq_req`=1 in the same cycle with `pc_id`=0xFFFF_FFFC -> `exception` pulse only, `epc`=0x0000_0000 (wrap), `redirect_pc`=0x8000_0008.
REQ-043 Scenario (kernel mode then return): in KERNEL, `irq_req`=1 and `exc_req`=1 -> no pulses, `nested_err`=1; then `eret`=1 -> IDLE, `kernel_mode`=0, `intterupt` pulse 2 cycles after `eret`.
REQ-044 Scenario (counter and reset): 256 taken events -> `taken_cnt`=0; then `reset`=0 mid-KERNEL -> all outputs 0 asynchronously, before the next clock edge.
